// File: rtl/gpio_defines.sv
// Shared GPIO address map and APB front-end state encoding.
package gpio_defines;

  localparam logic [31:0] GPIO_RGPIO_IN    = 32'h0000_0000;
  localparam logic [31:0] GPIO_RGPIO_OUT   = 32'h0000_0004;
  localparam logic [31:0] GPIO_RGPIO_OE    = 32'h0000_0008;
  localparam logic [31:0] GPIO_RGPIO_INTE  = 32'h0000_000C;
  localparam logic [31:0] GPIO_RGPIO_PTRIG = 32'h0000_0010;
  localparam logic [31:0] GPIO_RGPIO_AUX   = 32'h0000_0014;
  localparam logic [31:0] GPIO_RGPIO_CTRL  = 32'h0000_0018;
  localparam logic [31:0] GPIO_RGPIO_INTS  = 32'h0000_001C;
  localparam logic [31:0] GPIO_RGPIO_ECLK  = 32'h0000_0020;
  localparam logic [31:0] GPIO_RGPIO_NEC   = 32'h0000_0024;

  localparam logic [31:0] GPIO_LAST_ADDR   = 32'h0000_0024;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } apb_state_t;

endpackage

// File: rtl/gpio_addr_decode.sv
// Combinational GPIO address check: flags misaligned, unmapped and
// read-only-violating accesses.
module gpio_addr_decode
  import gpio_defines::*;
(
  input  logic [31:0] paddr,
  input  logic        pwrite,
  output logic        addr_err
);

  // Every word-aligned offset up to the last register is mapped, so a range
  // check plus an alignment check covers the whole map.
  always_comb begin
    addr_err = 1'b0;
    if (paddr[1:0] != 2'b00)
      addr_err = 1'b1;
    else if (paddr > GPIO_LAST_ADDR)
      addr_err = 1'b1;
    else if (pwrite && (paddr == GPIO_RGPIO_IN))
      addr_err = 1'b1;
  end

endmodule

// File: rtl/apb_gpio_if.sv
// APB3 slave front end for the GPIO register block: latches the setup
// phase, inserts WAIT_STATES access cycles, then issues a one-cycle write
// strobe or captures read data together with pready.
module apb_gpio_if
  import gpio_defines::*;
#(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  input  logic [31:0] gpio_dat_o,
  output logic        gpio_we,
  output logic [31:0] gpio_addr,
  output logic [31:0] gpio_dat_i
);

  apb_state_t state;
  logic [3:0] cnt;
  logic       wr_q;
  logic       err_q;
  logic       addr_err;

  gpio_addr_decode u_decode (
    .paddr    (paddr),
    .pwrite   (pwrite),
    .addr_err (addr_err)
  );

  // Transfer FSM; all outputs are registered here, so none of them has a
  // combinational path from the APB inputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      prdata     <= '0;
      pready     <= 1'b0;
      pslverr    <= 1'b0;
      gpio_we    <= 1'b0;
      gpio_addr  <= '0;
      gpio_dat_i <= '0;
    end else begin
      pready  <= 1'b0;
      pslverr <= 1'b0;
      gpio_we <= 1'b0;
      prdata  <= '0;
      case (state)
        IDLE: begin
          if (psel && !penable) begin
            gpio_addr  <= paddr;
            gpio_dat_i <= pwdata;
            wr_q       <= pwrite;
            err_q      <= addr_err;
            cnt        <= 4'(WAIT_STATES);
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (!psel) begin
            state <= IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state   <= DONE;
            pready  <= 1'b1;
            pslverr <= err_q;
            gpio_we <= wr_q && !err_q;
            prdata  <= (!wr_q && !err_q) ? gpio_dat_o : '0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_gpio_if.sv
// Directed bench for apb_gpio_if: two instances (WAIT_STATES 0 and 3), each
// backed by a small register-bank model, with a scoreboard of expected
// completions checked when pready rises.
module tb_apb_gpio_if;

  logic        sys_clk;
  logic        sys_rst;
  logic        psel       [2];
  logic        penable    [2];
  logic        pwrite     [2];
  logic [31:0] paddr      [2];
  logic [31:0] pwdata     [2];
  logic [31:0] prdata     [2];
  logic        pready     [2];
  logic        pslverr    [2];
  logic [31:0] gpio_dat_o [2];
  logic        gpio_we    [2];
  logic [31:0] gpio_addr  [2];
  logic [31:0] gpio_dat_i [2];

  int passed = 0;
  int total  = 0;

  typedef struct {
    string       tag;
    logic [31:0] rd;
    logic        err;
    logic        we;
  } exp_t;

  exp_t sb [$];

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] mem [16] = '{default: '0};

    apb_gpio_if #(.WAIT_STATES(g == 0 ? 0 : 3)) u_dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .psel       (psel[g]),
      .penable    (penable[g]),
      .pwrite     (pwrite[g]),
      .paddr      (paddr[g]),
      .pwdata     (pwdata[g]),
      .prdata     (prdata[g]),
      .pready     (pready[g]),
      .pslverr    (pslverr[g]),
      .gpio_dat_o (gpio_dat_o[g]),
      .gpio_we    (gpio_we[g]),
      .gpio_addr  (gpio_addr[g]),
      .gpio_dat_i (gpio_dat_i[g])
    );

    // Register-bank model: commits on the strobe, reads combinationally.
    always @(posedge sys_clk)
      if (gpio_we[g]) mem[gpio_addr[g][5:2]] <= gpio_dat_i[g];

    assign gpio_dat_o[g] = mem[gpio_addr[g][5:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk_zero(input int i, input string tag);
    chk({tag, "_pready"},  32'(pready[i]),  32'd0);
    chk({tag, "_we"},      32'(gpio_we[i]), 32'd0);
    chk({tag, "_pslverr"}, 32'(pslverr[i]), 32'd0);
    chk({tag, "_prdata"},  prdata[i],       32'd0);
    chk({tag, "_addr"},    gpio_addr[i],    32'd0);
    chk({tag, "_dat_i"},   gpio_dat_i[i],   32'd0);
  endtask

  // One complete APB transfer, starting in an IDLE cycle; returns in the
  // IDLE cycle after DONE so another call gives a back-to-back transfer.
  task automatic xfer(input int i, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] exp_rd,
                      input logic exp_err, input string tag);
    int   n;
    int   we_early;
    int   ws;
    exp_t e;
    ws = (i == 0) ? 0 : 3;
    sb.push_back('{tag: tag, rd: exp_rd, err: exp_err, we: wr && !exp_err});
    psel[i]    = 1'b1;
    penable[i] = 1'b0;
    pwrite[i]  = wr;
    paddr[i]   = a;
    pwdata[i]  = d;
    step();
    penable[i] = 1'b1;
    n = 1;
    we_early = 0;
    while (pready[i] !== 1'b1 && n < 40) begin
      if (gpio_we[i] === 1'b1) we_early++;
      step();
      n++;
    end
    chk({tag, "_len"}, 32'(n), 32'(ws + 2));
    e = sb.pop_front();
    chk({e.tag, "_pready"},  32'(pready[i]),  32'd1);
    chk({e.tag, "_prdata"},  prdata[i],       e.rd);
    chk({e.tag, "_pslverr"}, 32'(pslverr[i]), 32'(e.err));
    chk({e.tag, "_we"},      32'(gpio_we[i]), 32'(e.we));
    chk({e.tag, "_we_early"}, 32'(we_early),  32'd0);
    chk({e.tag, "_addr"},    gpio_addr[i],    a);
    if (e.we) chk({e.tag, "_dat_i"}, gpio_dat_i[i], d);
    psel[i]    = 1'b0;
    penable[i] = 1'b0;
    step();
    chk({tag, "_pready_off"}, 32'(pready[i]),  32'd0);
    chk({tag, "_we_off"},     32'(gpio_we[i]), 32'd0);
  endtask

  // Start a write on instance 1 and return in its second access cycle.
  task automatic start_w1(input logic [31:0] a, input logic [31:0] d);
    psel[1]    = 1'b1;
    penable[1] = 1'b0;
    pwrite[1]  = 1'b1;
    paddr[1]   = a;
    pwdata[1]  = d;
    step();
    penable[1] = 1'b1;
    step();
  endtask

  task automatic watch_quiet(input string tag);
    int rdy;
    int we;
    rdy = 0;
    we  = 0;
    repeat (6) begin
      step();
      if (pready[1] === 1'b1) rdy++;
      if (gpio_we[1] === 1'b1) we++;
    end
    chk({tag, "_pready"}, 32'(rdy), 32'd0);
    chk({tag, "_we"},     32'(we),  32'd0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      psel[i] = 1'b1; penable[i] = 1'b0; pwrite[i] = 1'b1;
      paddr[i] = 32'h4; pwdata[i] = 32'h1234_5678;
    end
    sys_rst = 1'b1;

    // Reset held for two cycles while a setup phase is presented.
    step();
    chk_zero(0, "rst1_i0");
    chk_zero(1, "rst1_i1");
    step();
    chk_zero(0, "rst2_i0");
    chk_zero(1, "rst2_i1");
    sys_rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      psel[i] = 1'b0; pwrite[i] = 1'b0;
    end
    step();

    xfer(0, 1'b0, 32'h04, 32'h0, 32'h0, 1'b0, "rd_out_rst");
    xfer(0, 1'b1, 32'h04, 32'hAAAA_5555, 32'h0, 1'b0, "wr_out");
    xfer(0, 1'b0, 32'h04, 32'h0, 32'hAAAA_5555, 1'b0, "rd_out");
    step();

    xfer(1, 1'b1, 32'h04, 32'h1234_5678, 32'h0, 1'b0, "ws3_wr");
    xfer(1, 1'b0, 32'h04, 32'h0, 32'h1234_5678, 1'b0, "ws3_rd");

    xfer(0, 1'b1, 32'h00, 32'hDEAD_BEEF, 32'h0, 1'b1, "err_wr_in");
    xfer(0, 1'b1, 32'h28, 32'hDEAD_BEEF, 32'h0, 1'b1, "err_wr_28");
    xfer(0, 1'b0, 32'h06, 32'h0, 32'h0, 1'b1, "err_rd_06");
    xfer(0, 1'b0, 32'h04, 32'h0, 32'hAAAA_5555, 1'b0, "rd_out_kept");
    xfer(0, 1'b1, 32'h24, 32'h0000_00C3, 32'h0, 1'b0, "wr_last");
    xfer(0, 1'b0, 32'h24, 32'h0, 32'h0000_00C3, 1'b0, "rd_last");
    xfer(0, 1'b0, 32'h00, 32'h0, 32'h0, 1'b0, "rd_in");

    // Back-to-back: second setup in the IDLE cycle right after DONE.
    xfer(0, 1'b1, 32'h08, 32'hFFFF_0000, 32'h0, 1'b0, "b2b_wr");
    xfer(0, 1'b0, 32'h08, 32'h0, 32'hFFFF_0000, 1'b0, "b2b_rd");
    step();

    // Abort by dropping psel in the second access cycle.
    start_w1(32'h04, 32'hBAD0_BAD0);
    psel[1]    = 1'b0;
    penable[1] = 1'b0;
    watch_quiet("abort");
    xfer(1, 1'b0, 32'h04, 32'h0, 32'h1234_5678, 1'b0, "abort_keep");

    // Same cut-off, but with a reset pulse instead.
    start_w1(32'h04, 32'hBAD1_BAD1);
    sys_rst = 1'b1;
    step();
    sys_rst    = 1'b0;
    chk_zero(1, "midrst");
    psel[1]    = 1'b0;
    penable[1] = 1'b0;
    watch_quiet("midrst_q");
    xfer(1, 1'b0, 32'h04, 32'h0, 32'h1234_5678, 1'b0, "midrst_keep");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/apb_gpio_if.md
# apb_gpio_if

APB slave front end for the GPIO register block: it converts APB3 transfers into the register block's single-cycle `gpio_we` / `gpio_addr` / `gpio_dat_i` write strobe and captures `gpio_dat_o` into `prdata`. It sits directly upstream of `register`. It adds a parameterised number of wait states and decodes the GPIO address map. It flags unmapped, misaligned and read-only-violating accesses with `pslverr`.

## Interface
- `WAIT_STATES`, default 0: extra access-phase cycles inserted before `pready`. Legal range is 0..15.
- `sys_clk  in  1`: the only clock; all logic updates on its rising edge.
- `sys_rst  in  1`: synchronous reset, active-high.
- `psel  in  1`: APB select.
- `penable  in  1`: APB enable; marks the access phase.
- `pwrite  in  1`: 1 = write, 0 = read.
- `paddr  in  32`: byte address.
- `pwdata  in  32`: write data.
- `prdata  out  32`: read data; valid only while `pready` = 1.
- `pready  out  1`: transfer complete.
- `pslverr  out  1`: transfer error; valid only while `pready` = 1.
- `gpio_dat_o  in  32`: read data from `register`; combinational on `gpio_addr`.
- `gpio_we  out  1`: one-cycle write strobe to `register`.
- `gpio_addr  out  32`: register address to `register`.
- `gpio_dat_i  out  32`: write data to `register`.

## Operation
- Address map, word-aligned: IN 0x00 (read-only), OUT 0x04, OE 0x08, INTE 0x0C, PTRIG 0x10, AUX 0x14, CTRL 0x18, INTS 0x1C, ECLK 0x20, NEC 0x24. All other offsets are unmapped.
- FSM states: IDLE, ACCESS, DONE.
- **IDLE**
  - When `psel`=1 and `penable`=0 (setup phase), latch the following on that edge and go to ACCESS:
    - `paddr` into `gpio_addr`;
    - `pwdata` into `gpio_dat_i`;
    - `pwrite`;
    - the error flag;
    - counter `cnt` = `WAIT_STATES`.
  - Otherwise stay in IDLE.
- **ACCESS**
  - If `psel`=0, abort: go to IDLE with no write and no `pready`.
  - Else if `cnt`≠0, decrement `cnt`.
  - Else go to DONE and, on that same edge, register:
    - `pready`=1;
    - `pslverr` = error flag;
    - `gpio_we` = `pwrite` AND NOT error;
    - `prdata` = (read AND NOT error) ? `gpio_dat_o` : 0.
- **DONE**
  - `pready` is high for exactly this one cycle.
  - `register` commits the write at the end of this cycle.
  - Next state is always IDLE. A back-to-back setup phase is accepted in the following IDLE cycle.
- Error flag is set when any of these holds:
  - `paddr[1:0]`≠0;
  - `paddr` is unmapped;
  - `pwrite`=1 with `paddr`=0x00 (write to IN).
- An erroring write never asserts `gpio_we`. An erroring read returns `prdata`=0.
- `gpio_addr` and `gpio_dat_i` hold their last latched value between transfers. `gpio_we` is 0 outside DONE.
- `prdata`, `pready` and `pslverr` are 0 in every state other than DONE.

## Timing
- Reset values: FSM = IDLE, `cnt`=0, and every output (`prdata`, `pready`, `pslverr`, `gpio_we`, `gpio_addr`, `gpio_dat_i`) = 0.
- Reset has priority over every other event, including a reset asserted mid-transfer:
  - the FSM returns to IDLE;
  - the pending write is dropped, and `gpio_we` is 0 in the cycle after reset.
- Setup cycle is T0. Access phase spans T1 … T(WAIT_STATES+2), and `pready` is high in T(WAIT_STATES+2).
  - Minimum transfer is 3 cycles (WAIT_STATES=0), with one mandatory wait state.
- `gpio_we` is high in the same cycle as `pready`.
- `prdata` is sampled from `gpio_dat_o` at the edge entering DONE. `gpio_addr` is stable from T1 onward.
- Every output is driven directly from a register; the block has no combinational path from any APB input to any APB output.

## Structure
- `gpio_defines.sv` holds:
  - the `GPIO_RGPIO_*` address constants;
  - the FSM state typedef (`apb_state_t`: IDLE, ACCESS, DONE);
  - `GPIO_LAST_ADDR` = 0x24.
- Sub-module `gpio_addr_decode`:
  - combinational;
  - inputs `paddr` and `pwrite`, output the error flag;
  - reused by future bus front ends.

## Test plan
- **Reset:** hold `sys_rst`=1 for 2 cycles with `psel`=1 → all outputs are 0 and no `pready`. After release, read OUT (0x04) → `prdata`=0x0000_0000, `pslverr`=0.
- **Write/readback:**
  - write 0x04 = 0xAAAA_5555 → `gpio_we` high exactly one cycle, coincident with `pready`, `gpio_dat_i`=0xAAAA_5555;
  - read 0x04 → `prdata`=0xAAAA_5555;
  - transfer length is 3 cycles at WAIT_STATES=0 and 6 cycles at WAIT_STATES=3.
- **Errors:**
  - write 0x00, write 0x28, read 0x06 → each completes with `pslverr`=1 and `gpio_we` never high;
  - the read returns `prdata`=0.
- **Back-to-back:** write 0x08 = 0xFFFF_0000 immediately followed by a setup for read 0x08 → second transfer completes with `prdata`=0xFFFF_0000 and no idle gap beyond the DONE→IDLE cycle.
- **Abort/reset mid-access:**
  - with WAIT_STATES=3, deassert `psel` in the 2nd access cycle → FSM returns to IDLE, no `gpio_we`, OUT unchanged;
  - repeat with `sys_rst` pulsed instead → same result.
